// File: rtl/lsa_pkg.sv
// Shared definitions for the load/store alignment unit: op codes, FSM states
// and the op decode helpers used by both the top level and the lane extender.
package lsa_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [3:0] OP_LW  = 4'd0;
  localparam logic [3:0] OP_LBU = 4'd1;
  localparam logic [3:0] OP_LB  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LH  = 4'd4;
  localparam logic [3:0] OP_LWU = 4'd5;
  localparam logic [3:0] OP_LD  = 4'd6;
  localparam logic [3:0] OP_SW  = 4'd8;
  localparam logic [3:0] OP_SB  = 4'd9;
  localparam logic [3:0] OP_SH  = 4'd10;
  localparam logic [3:0] OP_SD  = 4'd11;

  typedef struct packed {
    logic       legal;
    logic       store;
    logic [3:0] size;
  } op_info_t;

  // Doubleword-only codes are legal only when the datapath is 64 bits wide.
  function automatic op_info_t decode_op(input logic [3:0] op, input int dw);
    op_info_t info;
    info.legal = 1'b1;
    info.store = 1'b0;
    info.size  = 4'd4;
    case (op)
      OP_LW:         info.size = 4'd4;
      OP_LBU, OP_LB: info.size = 4'd1;
      OP_LHU, OP_LH: info.size = 4'd2;
      OP_LWU: begin
        info.size  = 4'd4;
        info.legal = (dw == 64);
      end
      OP_LD: begin
        info.size  = 4'd8;
        info.legal = (dw == 64);
      end
      OP_SW: begin
        info.store = 1'b1;
        info.size  = 4'd4;
      end
      OP_SB: begin
        info.store = 1'b1;
        info.size  = 4'd1;
      end
      OP_SH: begin
        info.store = 1'b1;
        info.size  = 4'd2;
      end
      OP_SD: begin
        info.store = 1'b1;
        info.size  = 4'd8;
        info.legal = (dw == 64);
      end
      default: info.legal = 1'b0;
    endcase
    return info;
  endfunction

  function automatic logic [7:0] size_lanes(input logic [3:0] size);
    logic [7:0] lanes;
    case (size)
      4'd1:    lanes = 8'h01;
      4'd2:    lanes = 8'h03;
      4'd4:    lanes = 8'h0F;
      4'd8:    lanes = 8'hFF;
      default: lanes = 8'h00;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/lane_extend.sv
// Selects the addressed lane from a raw memory word and zero/sign-extends it
// to the full data width according to the load op.
module lane_extend
  import lsa_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [$clog2(DW/8)-1:0] offset,
  input  logic [3:0]              op,
  input  logic [DW-1:0]           raw,
  output logic [DW-1:0]           extended
);

  logic [DW-1:0] shifted;

  always_comb begin
    shifted  = raw >> {offset, 3'b000};
    extended = '0;
    case (op)
      OP_LBU: extended = DW'(shifted[7:0]);
      OP_LB:  extended = DW'($signed(shifted[7:0]));
      OP_LHU: extended = DW'(shifted[15:0]);
      OP_LH:  extended = DW'($signed(shifted[15:0]));
      OP_LWU: extended = DW'(shifted[31:0]);
      OP_LW:  extended = DW'($signed(shifted[31:0]));
      OP_LD:  extended = shifted;
      default: extended = '0;
    endcase
  end

endmodule

// File: rtl/load_store_align.sv
// Single-outstanding load/store unit: checks alignment, issues one memory
// strobe with lane-shifted data/enables, and returns extended load data.
module load_store_align
  import lsa_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_op,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW-1:0]   req_wdata,
  output logic            resp_valid,
  output logic [DW-1:0]   resp_rdata,
  output logic            resp_exc,
  output logic            mem_en,
  output logic            mem_we,
  output logic [DW/8-1:0] mem_be,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_rvalid,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int NB = DW / 8;
  localparam int OW = $clog2(NB);

  state_t          state, state_nx;
  op_info_t        info_in;
  logic            req_bad;
  logic [3:0]      op_q;
  logic [3:0]      size_q;
  logic            store_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [OW-1:0]   offset;
  logic [NB-1:0]   lanes;
  logic [NB-1:0]   store_be;
  logic [DW-1:0]   wmask;
  logic [DW-1:0]   store_data;
  logic [AW-1:0]   aligned_addr;
  logic [DW-1:0]   load_data;

  // Illegal codes and misaligned addresses are resolved at accept time so
  // they never reach the memory.
  assign info_in = decode_op(req_op, DW);
  assign req_bad = !info_in.legal ||
                   (|(req_addr[2:0] & (info_in.size[2:0] - 3'd1)));

  assign offset       = addr_q[OW-1:0];
  assign lanes        = NB'(size_lanes(size_q));
  assign store_be     = lanes << offset;
  assign aligned_addr = {addr_q[AW-1:OW], {OW{1'b0}}};

  always_comb begin
    wmask = '0;
    for (int i = 0; i < NB; i++) begin
      wmask[8*i +: 8] = {8{lanes[i]}};
    end
    store_data = (wdata_q & wmask) << {offset, 3'b000};
  end

  lane_extend #(
    .DW(DW)
  ) u_lane_extend (
    .offset  (offset),
    .op      (op_q),
    .raw     (mem_rdata),
    .extended(load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op_q       <= '0;
      size_q     <= '0;
      store_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_rdata <= '0;
      resp_exc   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        op_q    <= req_op;
        size_q  <= info_in.size;
        store_q <= info_in.store;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        if (req_bad) begin
          resp_rdata <= '0;
          resp_exc   <= 1'b1;
        end
      end
      if (state == WAIT && mem_rvalid) begin
        resp_rdata <= store_q ? '0 : load_data;
        resp_exc   <= 1'b0;
      end
    end
  end

  // Memory-side outputs are only non-zero during the single ISSUE cycle.
  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = req_bad ? RESP : ISSUE;
      end
      ISSUE: begin
        mem_en    = 1'b1;
        mem_we    = store_q;
        mem_be    = store_q ? store_be : '1;
        mem_addr  = aligned_addr;
        mem_wdata = store_q ? store_data : '0;
        state_nx  = WAIT;
      end
      WAIT: begin
        if (mem_rvalid) state_nx = RESP;
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign resp_valid = (state == RESP);

endmodule
